multiplier_ctrl_v1: RTL and testbench
=====================================

// Module: multiplier_ctrl_v1
// PURPOSE
//  Sequencer for the 4-lane 8x8 byte-slice multiplier datapath of the RV32M accelerator.
//  - Accepts one MUL/MULH/MULHSU/MULHU request per valid/ready handshake.
//  - Issues the load, 4 rotate-and-accumulate steps and the pipeline drain.
//  - Signals completion when the accumulator holds the final 64-bit product.
//  - Sits between the decode/issue stage and the datapath; it drives every datapath control pin.
// PARAMETERS
//  none (all constants come from multiplier_pkg)
// PORTS
//  clk_i            in   1  clock, rising edge
//  rst_i            in   1  reset, synchronous, active-high
//  valid_i          in   1  request valid; operands are presented to the datapath in the same cycle
//  op_i             in   2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//  kill_i           in   1  abort the operation in flight (pipeline flush)
//  ready_o          out  1  controller can accept a request
//  busy_o           out  1  operation in flight (COMPUTE or DRAIN)
//  done_o           out  1  one-cycle pulse; datapath result valid
//  reg_A_en_o       out  1  load operand A, upper, signed_A and signed_B
//  reg_B_en_o       out  1  load/rotate operand B register
//  mux_B_sel_o      out  1  0 = external operand B, 1 = recirculate register B
//  rol_en_o         out  1  rotate B left by 8
//  en_pipe_o        out  1  advance the datapath pipeline registers
//  AC_en_o          out  1  tag the current step for accumulation
//  ac_clr_o         out  1  synchronous accumulator clear (datapath clear has priority over add)
//  signed_A_o       out  1  A is signed
//  signed_B_o       out  1  B is signed
//  upper_o          out  1  select result[63:32]
//  shift_amount_o   out  2  partial-product alignment for the current step
// BEHAVIOUR
//  States: IDLE, COMPUTE, DRAIN, DONE. There is a 2-bit step counter, step.
//  Reset: state=IDLE, step=0. Outputs at reset: ready_o=1, en_pipe_o=1; every other output is 0.
//  en_pipe_o=1 in every state, so the pipeline AC-enable flag flushes to 0.
//  AC_en_o=0 in all states other than COMPUTE.
//  Accept: accept = ready_o & valid_i. ready_o=1 in IDLE and in DONE. Accept is Mealy-decoded in the same cycle:
//   - reg_A_en_o=1, reg_B_en_o=1, mux_B_sel_o=0, rol_en_o=0, ac_clr_o=1.
//   - Next state is COMPUTE with step=0.
//  Op decode, driven only while accepting (0 otherwise):
//   - MUL:    sA=0, sB=0, up=0
//   - MULH:   sA=1, sB=1, up=1
//   - MULHSU: sA=1, sB=0, up=1
//   - MULHU:  sA=0, sB=0, up=1
//  COMPUTE:
//   - AC_en_o=1; shift_amount_o={step[1], step[1]^step[0]}, giving the sequence 00,01,11,10.
//   - Steps 0..2: reg_B_en_o=1, mux_B_sel_o=1, rol_en_o=1. Step 3: reg_B_en_o=0.
//   - reg_A_en_o=0, so the signed_B lane tag rotates together with B.
//   - Step increments each cycle. At step==3 the next state is DRAIN.
//  DRAIN: one cycle. The last product enters the accumulator and the pipeline AC flag clears. Next state is DONE.
//  DONE: done_o=1 for one cycle. A new accept in DONE goes directly to COMPUTE; otherwise the next state is IDLE.
//  Latency: accept in cycle T -> done_o in cycle T+6. Throughput is one operation per 6 cycles.
//  The result stays valid on the datapath output from DONE until the next accept (ac_clr_o).
//  kill_i:
//   - In COMPUTE or DRAIN: next state is IDLE, step=0, and done_o is suppressed.
//   - Any pending accumulate completes harmlessly and is cleared by the next accept.
//   - kill_i with valid_i in IDLE or DONE: kill wins and the request is not accepted.
//  rst_i mid-operation: same as reset; the partial result is discarded and done_o stays 0.
//  valid_i while busy_o=1 is ignored (ready_o=0); the requester must hold the request.
//  op_i is sampled only in the accept cycle.
// STRUCTURE
//  multiplier_pkg:
//   - state typedef/localparams (IDLE, COMPUTE, DRAIN, DONE)
//   - op encodings OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
//   - SHIFT_STEP0..3 = 00, 01, 11, 10
//   - N_STEPS = 4
//  No sub-module: the FSM, step counter and op decode stay in one file. The datapath is instantiated only in the bench.
// TESTING  (controller + datapath, checking result and cycle counts)
//  MUL 3 x 5, accept at T -> done_o at T+6, result 0x0000000F; ready_o low during T+1..T+5.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
//  MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000.
//  Trace shift_amount_o over steps 0..3 = 00,01,11,10; rol_en_o=1,1,1,0; AC_en_o high for exactly 4 cycles.
//  Back-to-back: valid_i held high, MUL 7x6 then MUL 2x9 -> done_o pulses 6 cycles apart, results 42 then 18.
//  kill_i at step 2 -> IDLE, no done_o; then MUL 4x4 -> 16. rst_i at DRAIN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared types and constants for the byte-slice multiplier sequencer.
package multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam logic [1:0] SHIFT_STEP0 = 2'b00;
  localparam logic [1:0] SHIFT_STEP1 = 2'b01;
  localparam logic [1:0] SHIFT_STEP2 = 2'b11;
  localparam logic [1:0] SHIFT_STEP3 = 2'b10;

  localparam int unsigned N_STEPS = 4;
  localparam logic [1:0] LAST_STEP = 2'(N_STEPS - 1);

  // Gray-coded alignment, so only one shift select bit toggles per step.
  function automatic logic [1:0] shift_for_step(input logic [1:0] step);
    logic [1:0] sh;
    sh = SHIFT_STEP0;
    case (step)
      2'd0:    sh = SHIFT_STEP0;
      2'd1:    sh = SHIFT_STEP1;
      2'd2:    sh = SHIFT_STEP2;
      default: sh = SHIFT_STEP3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/multiplier_ctrl_v1_if.sv
// Request handshake and datapath control bundle of the multiplier sequencer.
interface multiplier_ctrl_v1_if;
  logic       valid_i;
  logic [1:0] op_i;
  logic       kill_i;
  logic       ready_o;
  logic       busy_o;
  logic       done_o;
  logic       reg_A_en_o;
  logic       reg_B_en_o;
  logic       mux_B_sel_o;
  logic       rol_en_o;
  logic       en_pipe_o;
  logic       AC_en_o;
  logic       ac_clr_o;
  logic       signed_A_o;
  logic       signed_B_o;
  logic       upper_o;
  logic [1:0] shift_amount_o;

  modport master (
    output valid_i, op_i, kill_i,
    input  ready_o, busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o,
           rol_en_o, en_pipe_o, AC_en_o, ac_clr_o, signed_A_o, signed_B_o,
           upper_o, shift_amount_o
  );

  modport slave (
    input  valid_i, op_i, kill_i,
    output ready_o, busy_o, done_o, reg_A_en_o, reg_B_en_o, mux_B_sel_o,
           rol_en_o, en_pipe_o, AC_en_o, ac_clr_o, signed_A_o, signed_B_o,
           upper_o, shift_amount_o
  );
endinterface

// File: rtl/multiplier_ctrl_v1.sv
// Sequencer for the 4-lane 8x8 byte-slice multiplier: load, four
// rotate-and-accumulate steps, one drain cycle, then a done pulse.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for a request; ready
//  COMPUTE | four steps, B rotates between steps, partials tagged for AC
//  DRAIN   | last partial enters the accumulator, pipeline tag clears
//  DONE    | result valid, done pulse; may accept the next request
module multiplier_ctrl_v1
  import multiplier_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  multiplier_ctrl_v1_if.slave bus
);

  state_t     state_q, state_d;
  logic [1:0] step_q, step_d;
  logic       accept;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    step_d             = step_q;
    accept             = 1'b0;
    bus.ready_o        = 1'b0;
    bus.busy_o         = 1'b0;
    bus.done_o         = 1'b0;
    bus.reg_A_en_o     = 1'b0;
    bus.reg_B_en_o     = 1'b0;
    bus.mux_B_sel_o    = 1'b0;
    bus.rol_en_o       = 1'b0;
    bus.en_pipe_o      = 1'b1;
    bus.AC_en_o        = 1'b0;
    bus.ac_clr_o       = 1'b0;
    bus.signed_A_o     = 1'b0;
    bus.signed_B_o     = 1'b0;
    bus.upper_o        = 1'b0;
    bus.shift_amount_o = SHIFT_STEP0;

    case (state_q)
      ST_IDLE: begin
        bus.ready_o = 1'b1;
        if (state_d == ST_IDLE) step_d = 2'd0;
      end
      ST_COMPUTE: begin
        bus.busy_o         = 1'b1;
        bus.AC_en_o        = 1'b1;
        bus.shift_amount_o = shift_for_step(step_q);
        if (step_q != LAST_STEP) begin
          bus.reg_B_en_o  = 1'b1;
          bus.mux_B_sel_o = 1'b1;
          bus.rol_en_o    = 1'b1;
        end
        if (bus.kill_i) begin
          state_d = ST_IDLE;
          step_d  = 2'd0;
        end else begin
          step_d = step_q + 2'd1;
          if (step_q == LAST_STEP) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        bus.busy_o = 1'b1;
        step_d     = 2'd0;
        state_d    = bus.kill_i ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        bus.ready_o = 1'b1;
        bus.done_o  = 1'b1;
        step_d      = 2'd0;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 2'd0;
      end
    endcase

    // Kill overrides a request arriving in the same cycle.
    accept = bus.ready_o & bus.valid_i & ~bus.kill_i;
    if (accept) begin
      bus.reg_A_en_o  = 1'b1;
      bus.reg_B_en_o  = 1'b1;
      bus.mux_B_sel_o = 1'b0;
      bus.rol_en_o    = 1'b0;
      bus.ac_clr_o    = 1'b1;
      state_d         = ST_COMPUTE;
      step_d          = 2'd0;
      case (bus.op_i)
        OP_MULH: begin
          bus.signed_A_o = 1'b1;
          bus.signed_B_o = 1'b1;
          bus.upper_o    = 1'b1;
        end
        OP_MULHSU: begin
          bus.signed_A_o = 1'b1;
          bus.upper_o    = 1'b1;
        end
        OP_MULHU: begin
          bus.upper_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_ctrl_v1.sv
// Bench for multiplier_ctrl_v1 driving a behavioural byte-slice datapath;
// results and cycle counts are compared against a plain-arithmetic model.
module tb_multiplier_ctrl_v1;
  import multiplier_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multiplier_ctrl_v1_if mif ();
  multiplier_ctrl_v1 dut (.clk_i(clk), .rst_i(rst), .bus(mif));

  int checks = 0;
  int failures = 0;

  // Datapath: operand registers, one pipeline stage, 64-bit accumulator.
  logic [31:0] a_bus, b_bus, a_reg, b_reg;
  logic        sa_reg, sb_reg, up_reg, pipe_tag;
  logic [63:0] pipe_pp, acc;
  logic [31:0] result;
  assign result = up_reg ? acc[63:32] : acc[31:0];

  // Lane j multiplies A byte j with the rotated B byte j, which is original
  // B byte (j-k) after k rotations; the top bytes carry the sign flags.
  function automatic logic [63:0] lane_sum(input logic [31:0] a, input logic [31:0] br,
                                           input logic [1:0] sh, input logic sa, input logic sb);
    int k, bi;
    logic [63:0] s, ai, bj;
    logic [7:0] ab, bb;
    s = 64'd0;
    case (sh)
      2'b00:   k = 0;
      2'b01:   k = 1;
      2'b11:   k = 2;
      default: k = 3;
    endcase
    for (int j = 0; j < 4; j++) begin
      bi = (j - k + 4) % 4;
      ab = a[8*j +: 8];
      bb = br[8*j +: 8];
      ai = (j == 3 && sa) ? {{56{ab[7]}}, ab} : {56'd0, ab};
      bj = (bi == 3 && sb) ? {{56{bb[7]}}, bb} : {56'd0, bb};
      s  = s + ((ai * bj) << (8 * (j + bi)));
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      a_reg <= '0; b_reg <= '0; sa_reg <= 1'b0; sb_reg <= 1'b0; up_reg <= 1'b0;
      pipe_pp <= '0; pipe_tag <= 1'b0; acc <= '0;
    end else begin
      if (mif.reg_A_en_o) begin
        a_reg <= a_bus; sa_reg <= mif.signed_A_o; sb_reg <= mif.signed_B_o; up_reg <= mif.upper_o;
      end
      if (mif.reg_B_en_o)
        b_reg <= !mif.mux_B_sel_o ? b_bus : (mif.rol_en_o ? {b_reg[23:0], b_reg[31:24]} : b_reg);
      if (mif.en_pipe_o) begin
        pipe_pp  <= lane_sum(a_reg, b_reg, mif.shift_amount_o, sa_reg, sb_reg);
        pipe_tag <= mif.AC_en_o;
      end
      if (mif.ac_clr_o) acc <= '0;
      else if (pipe_tag) acc <= acc + pipe_pp;
    end
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == OP_MULH || op == OP_MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == OP_MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [14:0] outv();
    return {mif.ready_o, mif.busy_o, mif.done_o, mif.reg_A_en_o, mif.reg_B_en_o,
            mif.mux_B_sel_o, mif.rol_en_o, mif.en_pipe_o, mif.AC_en_o, mif.ac_clr_o,
            mif.signed_A_o, mif.signed_B_o, mif.upper_o, mif.shift_amount_o};
  endfunction

  localparam logic [14:0] RESET_OUTS = 15'h4080;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it to done; operands are scrambled after
  // the accept cycle since the controller must sample them only there.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    int lat, rdy_hi;
    bit seen;
    mif.valid_i = 1'b1; mif.op_i = op; a_bus = a; b_bus = b;
    #1;
    chk({nm, " ready"}, 64'(mif.ready_o), 64'd1);
    lat = 0; seen = 1'b0; rdy_hi = 0;
    while (!seen && lat < 20) begin
      tick();
      mif.valid_i = 1'b0; mif.op_i = 2'($urandom); a_bus = $urandom; b_bus = $urandom;
      #1;
      lat++;
      if (mif.done_o) seen = 1'b1;
      else if (mif.ready_o) rdy_hi++;
    end
    chk({nm, " latency"}, 64'(lat), 64'd6);
    chk({nm, " result"}, 64'(result), 64'(exp));
    chk({nm, " ready_low"}, 64'(rdy_hi), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int d1, d2, cnt, ac_cnt;
    logic [31:0] r1, r2, ra, rb;
    logic [1:0] rop;
    logic [7:0] sh_trace;
    logic [3:0] rol_trace;

    vecs[0] = '{OP_MUL,    32'd3,          32'd5,          32'h0000000F};
    vecs[1] = '{OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
    vecs[2] = '{OP_MULH,   32'h80000000,   32'h80000000,   32'h40000000};
    vecs[3] = '{OP_MULHSU, 32'hFFFFFFFF,   32'h00000002,   32'hFFFFFFFF};
    vecs[4] = '{OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000};
    vecs[5] = '{OP_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
    vecs[6] = '{OP_MULHSU, 32'h00000002,   32'hFFFFFFFF,   32'h00000001};
    vecs[7] = '{OP_MULHU,  32'h00010000,   32'h00010000,   32'h00000001};

    mif.valid_i = 1'b0; mif.op_i = 2'b00; mif.kill_i = 1'b0;
    a_bus = '0; b_bus = '0;
    rst = 1'b1;
    repeat (3) tick();
    #1;
    chk("reset_outs", 64'(outv()), 64'(RESET_OUTS));
    rst = 1'b0;
    tick(); #1;
    chk("idle_outs", 64'(outv()), 64'(RESET_OUTS));

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      tick();
    end

    // Step trace: alignment codes, rotate enables, accumulate tag count.
    mif.valid_i = 1'b1; mif.op_i = OP_MUL; a_bus = 32'd3; b_bus = 32'd5;
    #1;
    ac_cnt = int'(mif.AC_en_o);
    sh_trace = '0; rol_trace = '0;
    for (int n = 1; n <= 7; n++) begin
      tick(); mif.valid_i = 1'b0; #1;
      if (n <= 4) begin
        sh_trace  = {sh_trace[5:0], mif.shift_amount_o};
        rol_trace = {rol_trace[2:0], mif.rol_en_o};
      end
      ac_cnt += int'(mif.AC_en_o);
    end
    chk("shift_trace", 64'(sh_trace), 64'h1E);
    chk("rol_trace", 64'(rol_trace), 64'hE);
    chk("ac_en_cycles", 64'(ac_cnt), 64'd4);

    // Back-to-back with valid held high.
    mif.valid_i = 1'b1; mif.op_i = OP_MUL; a_bus = 32'd7; b_bus = 32'd6;
    #1;
    d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 1) begin a_bus = 32'd2; b_bus = 32'd9; end
      #1;
      if (mif.done_o) begin
        if (d1 < 0) begin d1 = n; r1 = result; end
        else if (d2 < 0) begin d2 = n; r2 = result; mif.valid_i = 1'b0; end
      end
    end
    mif.valid_i = 1'b0;
    chk("b2b_first_latency", 64'(d1), 64'd6);
    chk("b2b_spacing", 64'(d2 - d1), 64'd6);
    chk("b2b_first_result", 64'(r1), 64'd42);
    chk("b2b_second_result", 64'(r2), 64'd18);

    // Kill at step 2.
    tick();
    mif.valid_i = 1'b1; mif.op_i = OP_MUL; a_bus = 32'd9; b_bus = 32'd9;
    #1;
    tick(); mif.valid_i = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    chk("kill_at_step2_shift", 64'(mif.shift_amount_o), 64'(SHIFT_STEP2));
    mif.kill_i = 1'b1;
    tick(); mif.kill_i = 1'b0; #1;
    chk("kill_idle", 64'({mif.ready_o, mif.busy_o}), 64'b10);
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick(); #1;
      cnt += int'(mif.done_o);
    end
    chk("kill_no_done", 64'(cnt), 64'd0);
    do_op(OP_MUL, 32'd4, 32'd4, 32'd16, "after_kill");
    tick();

    // Kill together with valid in IDLE: nothing accepted.
    mif.valid_i = 1'b1; mif.kill_i = 1'b1; mif.op_i = OP_MULH;
    #1;
    chk("kill_vs_valid_load", 64'({mif.reg_A_en_o, mif.ac_clr_o}), 64'd0);
    tick(); mif.valid_i = 1'b0; mif.kill_i = 1'b0; #1;
    chk("kill_vs_valid_busy", 64'(mif.busy_o), 64'd0);

    // Reset during DRAIN.
    mif.valid_i = 1'b1; mif.op_i = OP_MULHU; a_bus = $urandom; b_bus = $urandom;
    #1;
    tick(); mif.valid_i = 1'b0; #1;
    repeat (4) tick();
    #1;
    chk("drain_busy", 64'(mif.busy_o), 64'd1);
    rst = 1'b1;
    tick(); #1;
    chk("rst_at_drain_outs", 64'(outv()), 64'(RESET_OUTS));
    rst = 1'b0;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick(); #1;
      cnt += int'(mif.done_o);
    end
    chk("rst_no_done", 64'(cnt), 64'd0);

    // Randomized requests against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if (i % 7 == 0) ra = 32'h80000000;
      if (i % 5 == 0) rb = 32'hFFFFFFFF;
      do_op(rop, ra, rb, ref_mul(rop, ra, rb), $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
